// File: rtl/jtag_ctl_pkg.sv
// jtag_ctl_pkg: shared FSM encoding, synced-input indices and parity helper
package jtag_ctl_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    localparam int J_DRCK  = 0;
    localparam int J_SEL   = 1;
    localparam int J_SHIFT = 2;
    localparam int J_CAP   = 3;
    localparam int J_UPD   = 4;
    localparam int J_RST   = 5;
    localparam int J_TDI   = 6;
    localparam int J_N     = 7;
    // Zero-extension to 64 bits leaves even parity unchanged.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: multi-flop synchronizer with rising-edge pulse in usbclk domain
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic usbclk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
endmodule

// File: rtl/jtag_ctl_bridge.sv
// jtag_ctl_bridge: BSCAN user-chain to parity-checked control word bridge
module jtag_ctl_bridge
    import jtag_ctl_pkg::*;
#(
    parameter int DW          = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic          usbclk,
    input  logic          rst_n,
    input  logic          jtag_drck,
    input  logic          jtag_sel,
    input  logic          jtag_shift,
    input  logic          jtag_capture,
    input  logic          jtag_update,
    input  logic          jtag_reset,
    input  logic          jtag_tdi,
    output logic          jtag_tdo,
    input  logic [DW-1:0] rb_data,
    output logic [DW-1:0] control_bus,
    output logic          control_strobe,
    output logic          frame_err,
    output logic [7:0]    err_count
);
    localparam int CW = $clog2(DW + 3);
    logic [J_N-1:0] raw, lvl, rise;
    state_t state, state_n;
    logic [DW:0] tx, rx;
    logic [CW-1:0] cnt;
    logic load, commit, shift_en, valid;
    logic unused_sync;
    assign raw = {jtag_tdi, jtag_reset, jtag_update, jtag_capture, jtag_shift, jtag_sel, jtag_drck};
    for (genvar i = 0; i < J_N; i++) begin : g_sync
        jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .usbclk(usbclk),
            .rst_n (rst_n),
            .din   (raw[i]),
            .level (lvl[i]),
            .rise  (rise[i])
        );
    end
    assign unused_sync = ^{rise[J_SEL], rise[J_SHIFT], rise[J_RST], rise[J_TDI],
                           lvl[J_DRCK], lvl[J_CAP], lvl[J_UPD]};
    always_comb begin
        state_n  = lvl[J_RST] ? IDLE :
                   (state == IDLE  && rise[J_CAP] && lvl[J_SEL]) ? SHIFT :
                   (state == SHIFT && rise[J_UPD] && lvl[J_SEL]) ? COMMIT :
                   (state == COMMIT) ? IDLE : state;
        load     = state == IDLE && state_n == SHIFT;
        commit   = state == SHIFT && state_n == COMMIT;
        shift_en = state == SHIFT && !lvl[J_RST] && rise[J_DRCK] && lvl[J_SEL] && lvl[J_SHIFT];
        valid    = cnt == CW'(DW + 1) && !(^rx);
    end
    // Commit outputs are registered on the SHIFT->COMMIT edge so they are visible during COMMIT.
    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tx             <= '0;
            rx             <= '0;
            cnt            <= '0;
            jtag_tdo       <= 1'b0;
            control_bus    <= '0;
            control_strobe <= 1'b0;
            frame_err      <= 1'b0;
            err_count      <= 8'd0;
        end else begin
            state          <= state_n;
            jtag_tdo       <= tx[DW];
            control_strobe <= commit && valid;
            frame_err      <= commit && !valid;
            if (lvl[J_RST]) begin
                rx  <= '0;
                cnt <= '0;
            end else if (load) begin
                tx  <= {rb_data, even_par(64'(rb_data))};
                rx  <= '0;
                cnt <= '0;
            end else if (shift_en) begin
                rx  <= {rx[DW-1:0], lvl[J_TDI]};
                tx  <= {tx[DW-1:0], 1'b0};
                cnt <= (cnt == CW'(DW + 2)) ? cnt : cnt + CW'(1);
            end
            if (commit && valid)
                control_bus <= rx[DW:1];
            if (commit && !valid && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_jtag_ctl_bridge.sv
// tb_jtag_ctl_bridge: directed self-checking bench for jtag_ctl_bridge (DW=40)
module tb_jtag_ctl_bridge;
    localparam int DW = 40;
    logic usbclk = 1'b0;
    logic rst_n = 1'b0;
    logic jtag_drck = 1'b0, jtag_sel = 1'b0, jtag_shift = 1'b0, jtag_capture = 1'b0;
    logic jtag_update = 1'b0, jtag_reset = 1'b0, jtag_tdi = 1'b0;
    logic jtag_tdo;
    logic [DW-1:0] rb_data = '0;
    logic [DW-1:0] control_bus;
    logic control_strobe, frame_err;
    logic [7:0] err_count;
    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_bus = '0;
    int exp_err = 0;
    logic [DW-1:0] d;

    jtag_ctl_bridge #(.DW(DW), .SYNC_STAGES(2)) dut (
        .usbclk        (usbclk),
        .rst_n         (rst_n),
        .jtag_drck     (jtag_drck),
        .jtag_sel      (jtag_sel),
        .jtag_shift    (jtag_shift),
        .jtag_capture  (jtag_capture),
        .jtag_update   (jtag_update),
        .jtag_reset    (jtag_reset),
        .jtag_tdi      (jtag_tdi),
        .jtag_tdo      (jtag_tdo),
        .rb_data       (rb_data),
        .control_bus   (control_bus),
        .control_strobe(control_strobe),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    always #5 usbclk = ~usbclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge usbclk);
    endtask

    task automatic capture_t();
        jtag_capture = 1'b1;
        wclk(4);
        jtag_capture = 1'b0;
        wclk(4);
    endtask

    // n bits: data MSB first, then parity, then zero padding; optional tdo readback check
    task automatic shift_bits(input logic [DW-1:0] dat, input logic par, input int n, input logic chk);
        logic [DW:0] tx;
        tx = {rb_data, ^rb_data};
        jtag_shift = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (chk)
                check($sformatf("tdo[%0d]", i), 64'(jtag_tdo), 64'((i <= DW) ? tx[DW-i] : 1'b0));
            jtag_tdi = (i < DW) ? dat[DW-1-i] : ((i == DW) ? par : 1'b0);
            jtag_drck = 1'b1;
            wclk(4);
            jtag_drck = 1'b0;
            wclk(4);
        end
        jtag_shift = 1'b0;
        wclk(2);
    endtask

    // Strobe / error expected on the 3rd sample: 2 sync stages, then 1 cycle to commit.
    task automatic update_t(input logic ok, input logic fe, input string tag);
        logic [5:0] st_seq, fe_seq;
        jtag_update = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge usbclk);
            st_seq[i] = control_strobe;
            fe_seq[i] = frame_err;
        end
        jtag_update = 1'b0;
        wclk(4);
        if (fe)
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        check($sformatf("%s strobe", tag), 64'(st_seq), ok ? 64'h4 : 64'h0);
        check($sformatf("%s frame_err", tag), 64'(fe_seq), fe ? 64'h4 : 64'h0);
        check($sformatf("%s bus", tag), 64'(control_bus), 64'(exp_bus));
        check($sformatf("%s err_count", tag), 64'(err_count), 64'(exp_err));
    endtask

    initial begin
        wclk(3);
        check("rst bus", 64'(control_bus), 64'h0);
        check("rst strobe", 64'(control_strobe), 64'h0);
        check("rst frame_err", 64'(frame_err), 64'h0);
        check("rst err_count", 64'(err_count), 64'h0);
        check("rst tdo", 64'(jtag_tdo), 64'h0);
        jtag_sel = 1'b1;
        rst_n = 1'b1;
        wclk(3);

        rb_data = 40'hC3_1234_5678;
        d = 40'h12_3456_789A;
        capture_t();
        shift_bits(d, ^d, 41, 1'b1);
        exp_bus = d;
        update_t(1'b1, 1'b0, "good");

        capture_t();
        shift_bits(d, ~^d, 41, 1'b1);
        update_t(1'b0, 1'b1, "badpar");

        capture_t();
        shift_bits(d, ^d, 39, 1'b1);
        update_t(1'b0, 1'b1, "short39");

        capture_t();
        shift_bits(d, ^d, 43, 1'b1);
        update_t(1'b0, 1'b1, "long43");

        d = 40'hDE_ADBE_EF01;
        capture_t();
        shift_bits(d, ^d, 41, 1'b1);
        jtag_sel = 1'b0;
        update_t(1'b0, 1'b0, "sel0");
        jtag_sel = 1'b1;
        exp_bus = d;
        update_t(1'b1, 1'b0, "sel1");

        rb_data = 40'hA5_A5A5_A5A5;
        d = 40'hA5_A5A5_A5A5;
        capture_t();
        shift_bits(d, 1'b0, 41, 1'b1);
        exp_bus = d;
        update_t(1'b1, 1'b0, "a5");

        capture_t();
        shift_bits(d, 1'b0, 20, 1'b1);
        jtag_reset = 1'b1;
        wclk(4);
        jtag_reset = 1'b0;
        wclk(4);
        update_t(1'b0, 1'b0, "jreset");

        capture_t();
        shift_bits(d, 1'b0, 10, 1'b0);
        rst_n = 1'b0;
        wclk(2);
        check("midrst bus", 64'(control_bus), 64'h0);
        check("midrst err_count", 64'(err_count), 64'h0);
        rst_n = 1'b1;
        wclk(2);
        exp_bus = '0;
        exp_err = 0;
        shift_bits(d, 1'b0, 41, 1'b0);
        update_t(1'b0, 1'b0, "nocapture");

        for (int k = 0; k < 300; k++) begin
            capture_t();
            update_t(1'b0, 1'b1, "sat");
        end
        check("sat final", 64'(err_count), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
